// File: rtl/regfile_test_sequencer_if.sv
// Datapath-facing link of the regfile test sequencer: writeback stream and halt in, datapath reset out.
interface regfile_test_sequencer_if #(
   parameter int unsigned XLEN = 64
) ();
   logic            wb_en;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            halt;
   logic            dut_rst;

   // master is the datapath side, slave is the sequencer
   modport master (output wb_en, wb_rd, wb_data, halt, input dut_rst);
   modport slave  (input wb_en, wb_rd, wb_data, halt, output dut_rst);
endinterface

// File: rtl/regfile_test_sequencer.sv
// Hardware test harness for the RV64I datapath: resets it, runs it for a budget or until halt,
// shadows the register file from writeback and checks a table of expected register values.
module regfile_test_sequencer #(
   parameter int unsigned XLEN       = 64,
   parameter int unsigned NCHECK     = 8,
   parameter int unsigned RST_CYCLES = 1,
   parameter int unsigned CNT_W      = 16,
   localparam int unsigned IW        = (NCHECK > 1) ? $clog2(NCHECK) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [CNT_W-1:0]          run_cycles,
   input  logic                      cfg_we,
   input  logic [IW-1:0]             cfg_idx,
   input  logic                      cfg_valid,
   input  logic [4:0]                cfg_rd,
   input  logic [XLEN-1:0]           cfg_data,
   regfile_test_sequencer_if.slave   dp,
   output logic                      busy,
   output logic                      done,
   output logic                      pass,
   output logic [IW-1:0]             fail_idx,
   output logic [XLEN-1:0]           fail_exp,
   output logic [XLEN-1:0]           fail_got,
   output logic [CNT_W-1:0]          test_count,
   output logic [CNT_W-1:0]          cycle_count
);

   localparam int unsigned RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RESET,
      S_RUN,
      S_CHECK,
      S_DONE
   } state_t;

   state_t state, state_next;

   logic [RW-1:0]    rst_cnt, rst_cnt_next;
   logic [IW-1:0]    chk_idx, chk_idx_next;
   logic [CNT_W-1:0] cycle_count_next, test_count_next, budget;
   logic             pass_next;
   logic [IW-1:0]    fail_idx_next;
   logic [XLEN-1:0]  fail_exp_next, fail_got_next;
   logic             shadow_we, shadow_clr, tbl_we;

   logic [XLEN-1:0]  shadow   [32];
   logic             tbl_valid [NCHECK];
   logic [4:0]       tbl_rd   [NCHECK];
   logic [XLEN-1:0]  tbl_data [NCHECK];

   assign budget = (run_cycles == '0) ? CNT_W'(1) : run_cycles;

   // next-state and next-value logic
   always_comb begin
      state_next       = state;
      rst_cnt_next     = rst_cnt;
      chk_idx_next     = chk_idx;
      cycle_count_next = cycle_count;
      test_count_next  = test_count;
      pass_next        = pass;
      fail_idx_next    = fail_idx;
      fail_exp_next    = fail_exp;
      fail_got_next    = fail_got;
      shadow_we        = 1'b0;
      shadow_clr       = 1'b0;
      tbl_we           = 1'b0;

      case (state)
         S_IDLE, S_DONE: begin
            tbl_we = cfg_we && (32'(cfg_idx) < NCHECK);
            if (start) begin
               state_next       = S_RESET;
               rst_cnt_next     = '0;
               chk_idx_next     = '0;
               cycle_count_next = '0;
               pass_next        = 1'b0;
               fail_idx_next    = '0;
               fail_exp_next    = '0;
               fail_got_next    = '0;
               shadow_clr       = 1'b1;
            end
         end
         S_RESET: begin
            if (rst_cnt == RW'(RST_CYCLES - 1)) state_next = S_RUN;
            else                                rst_cnt_next = rst_cnt + 1'b1;
         end
         S_RUN: begin
            shadow_we = dp.wb_en && (dp.wb_rd != 5'd0);
            if (cycle_count != '1) cycle_count_next = cycle_count + 1'b1;
            if (dp.halt || (cycle_count_next >= budget)) state_next = S_CHECK;
         end
         S_CHECK: begin
            if (tbl_valid[chk_idx] && (shadow[tbl_rd[chk_idx]] != tbl_data[chk_idx])) begin
               fail_idx_next = chk_idx;
               fail_exp_next = tbl_data[chk_idx];
               fail_got_next = shadow[tbl_rd[chk_idx]];
               pass_next     = 1'b0;
               state_next    = S_DONE;
            end else if (chk_idx == IW'(NCHECK - 1)) begin
               pass_next  = 1'b1;
               state_next = S_DONE;
            end else begin
               chk_idx_next = chk_idx + 1'b1;
            end
         end
         default: state_next = S_IDLE;
      endcase

      if ((state_next == S_DONE) && (state != S_DONE)) test_count_next = test_count + 1'b1;
   end

   // state register and registered control outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         rst_cnt     <= '0;
         chk_idx     <= '0;
         cycle_count <= '0;
         test_count  <= '0;
         pass        <= 1'b0;
         fail_idx    <= '0;
         fail_exp    <= '0;
         fail_got    <= '0;
         dp.dut_rst  <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_next;
         rst_cnt     <= rst_cnt_next;
         chk_idx     <= chk_idx_next;
         cycle_count <= cycle_count_next;
         test_count  <= test_count_next;
         pass        <= pass_next;
         fail_idx    <= fail_idx_next;
         fail_exp    <= fail_exp_next;
         fail_got    <= fail_got_next;
         dp.dut_rst  <= (state_next != S_RUN);
         busy        <= (state_next == S_RESET) || (state_next == S_RUN) || (state_next == S_CHECK);
         done        <= (state_next == S_DONE);
      end
   end

   // shadow register file, x0 never written
   always_ff @(posedge clk) begin
      if (rst || shadow_clr) begin
         for (int i = 0; i < 32; i++) shadow[i] <= '0;
      end else if (shadow_we) begin
         shadow[dp.wb_rd] <= dp.wb_data;
      end
   end

   // expected-value table
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NCHECK); i++) begin
            tbl_valid[i] <= 1'b0;
            tbl_rd[i]    <= '0;
            tbl_data[i]  <= '0;
         end
      end else if (tbl_we) begin
         tbl_valid[cfg_idx] <= cfg_valid;
         tbl_rd[cfg_idx]    <= cfg_rd;
         tbl_data[cfg_idx]  <= cfg_data;
      end
   end

endmodule

// File: tb/tb_regfile_test_sequencer.sv
// Directed self-checking bench for regfile_test_sequencer with hand-computed expectations.
module tb_regfile_test_sequencer;
   localparam int unsigned XLEN   = 64;
   localparam int unsigned NCHECK = 8;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned IW     = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [CNT_W-1:0] run_cycles;
   logic             cfg_we;
   logic [IW-1:0]    cfg_idx;
   logic             cfg_valid;
   logic [4:0]       cfg_rd;
   logic [XLEN-1:0]  cfg_data;
   logic             busy, done, pass;
   logic [IW-1:0]    fail_idx;
   logic [XLEN-1:0]  fail_exp, fail_got;
   logic [CNT_W-1:0] test_count, cycle_count;

   int n_checks = 0;
   int n_fail   = 0;
   int t_since  = 0;

   regfile_test_sequencer_if #(.XLEN(XLEN)) dp_if ();

   regfile_test_sequencer #(
      .XLEN(XLEN), .NCHECK(NCHECK), .RST_CYCLES(1), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .run_cycles(run_cycles),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_valid(cfg_valid), .cfg_rd(cfg_rd),
      .cfg_data(cfg_data), .dp(dp_if), .busy(busy), .done(done), .pass(pass),
      .fail_idx(fail_idx), .fail_exp(fail_exp), .fail_got(fail_got),
      .test_count(test_count), .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      t_since++;
   endtask

   task automatic cfg_write(input int idx, input logic v, input logic [4:0] rd, input logic [63:0] d);
      cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_valid = v; cfg_rd = rd; cfg_data = d;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic clear_table();
      for (int i = 0; i < int'(NCHECK); i++) cfg_write(i, 1'b0, 5'd0, 64'd0);
   endtask

   task automatic start_test();
      t_since = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wb(input logic [4:0] rd, input logic [63:0] d);
      dp_if.wb_en = 1'b1; dp_if.wb_rd = rd; dp_if.wb_data = d;
      tick();
      dp_if.wb_en = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int exp_lat);
      int n = 0;
      while (!done && n < 200) begin
         tick();
         n++;
      end
      check({tag, "_done"}, done, 1);
      check({tag, "_lat"}, t_since, exp_lat);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; run_cycles = '0; cfg_we = 1'b0; cfg_idx = '0;
      cfg_valid = 1'b0; cfg_rd = '0; cfg_data = '0;
      dp_if.wb_en = 1'b0; dp_if.wb_rd = '0; dp_if.wb_data = '0; dp_if.halt = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();

      check("rst_dut_rst", dp_if.dut_rst, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_fail_exp", fail_exp, 0);
      check("rst_test_count", test_count, 0);
      check("rst_cycle_count", cycle_count, 0);

      // T1: two matching entries, full budget
      cfg_write(0, 1'b1, 5'd4, 64'd11);
      cfg_write(1, 1'b1, 5'd3, 64'd12);
      run_cycles = 16'd10;
      start_test();
      check("t1_busy_rst", busy, 1);
      check("t1_dut_rst_hi", dp_if.dut_rst, 1);
      tick();
      check("t1_dut_rst_lo", dp_if.dut_rst, 0);
      wb(5'd3, 64'd12);
      wb(5'd4, 64'd11);
      wait_done("t1", 20);
      check("t1_pass", pass, 1);
      check("t1_test_count", test_count, 1);
      check("t1_cycle_count", cycle_count, 10);
      check("t1_busy_done", busy, 0);

      // T2: overwritten value mismatches on the first entry
      clear_table();
      cfg_write(0, 1'b1, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF);
      run_cycles = 16'd3;
      start_test();
      tick();
      wb(5'd4, 64'hFFFF_FFFF_FFFF_FFFF);
      wb(5'd4, 64'd5);
      wait_done("t2", 6);
      check("t2_pass", pass, 0);
      check("t2_fail_idx", fail_idx, 0);
      check("t2_fail_exp", fail_exp, 64'hFFFF_FFFF_FFFF_FFFF);
      check("t2_fail_got", fail_got, 5);
      check("t2_test_count", test_count, 2);

      // T3: x0 stays zero; entry 2 behind two invalid entries
      clear_table();
      cfg_write(2, 1'b1, 5'd0, 64'd0);
      run_cycles = 16'd2;
      start_test();
      tick();
      wb(5'd0, 64'd7);
      wait_done("t3a", 12);
      check("t3a_pass", pass, 1);
      cfg_write(2, 1'b1, 5'd0, 64'd7);
      start_test();
      tick();
      wb(5'd0, 64'd7);
      wait_done("t3b", 7);
      check("t3b_pass", pass, 0);
      check("t3b_fail_idx", fail_idx, 2);
      check("t3b_fail_exp", fail_exp, 7);
      check("t3b_fail_got", fail_got, 0);

      // T4: halt on RUN cycle 4 with a coincident writeback
      clear_table();
      cfg_write(0, 1'b1, 5'd1, 64'd8);
      run_cycles = 16'd100;
      start_test();
      tick();
      tick(); tick(); tick();
      dp_if.halt = 1'b1;
      wb(5'd1, 64'd8);
      dp_if.halt = 1'b0;
      wait_done("t4", 14);
      check("t4_cycle_count", cycle_count, 4);
      check("t4_pass", pass, 1);
      check("t4_test_count", test_count, 5);

      // T5: reset in the middle of RUN clears everything
      run_cycles = 16'd50;
      start_test();
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_busy", busy, 0);
      check("t5_done", done, 0);
      check("t5_dut_rst", dp_if.dut_rst, 1);
      check("t5_test_count", test_count, 0);
      check("t5_cycle_count", cycle_count, 0);
      run_cycles = 16'd2;
      start_test();
      wait_done("t5", 12);
      check("t5_pass", pass, 1);
      check("t5_test_count_after", test_count, 1);

      // T6: start and cfg_we ignored while busy
      cfg_write(0, 1'b1, 5'd2, 64'd9);
      run_cycles = 16'd3;
      start_test();
      start = 1'b1; cfg_we = 1'b1; cfg_idx = '0; cfg_valid = 1'b1; cfg_rd = 5'd2; cfg_data = 64'd123;
      tick();
      wb(5'd2, 64'd9);
      start = 1'b0; cfg_we = 1'b0;
      check("t6_busy", busy, 1);
      wait_done("t6", 13);
      check("t6_pass", pass, 1);
      check("t6_test_count", test_count, 2);

      // T6b: shadow cleared between back-to-back tests
      run_cycles = 16'd2;
      start_test();
      wait_done("t6b", 5);
      check("t6b_pass", pass, 0);
      check("t6b_fail_exp", fail_exp, 9);
      check("t6b_fail_got", fail_got, 0);
      check("t6b_test_count", test_count, 3);

      // T6c: table write in the start cycle is kept
      cfg_write(0, 1'b0, 5'd0, 64'd0);
      t_since = 0;
      start = 1'b1; cfg_we = 1'b1; cfg_idx = '0; cfg_valid = 1'b1; cfg_rd = 5'd2; cfg_data = 64'd9;
      tick();
      start = 1'b0; cfg_we = 1'b0;
      wait_done("t6c", 5);
      check("t6c_pass", pass, 0);
      check("t6c_fail_exp", fail_exp, 9);

      // T7: zero budget behaves as one cycle
      run_cycles = 16'd0;
      start_test();
      wait_done("t7", 4);
      check("t7_cycle_count", cycle_count, 1);
      check("t7_pass", pass, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
